// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter sharing one UART TX byte stream between NUM_REQ
// requesters. A requester keeps the grant for a whole message, which ends
// with a byte flagged 'last', so messages never interleave on the line.
// The output byte register feeds the input side of the TX CDC FIFO.
//
// Optional feature macro: UART_ARB_TIMEOUT_EN
//   defined   : a lock with no owner byte for IDLE_TIMEOUT cycles is
//               force-released and timeout_o pulses for one cycle.
//   undefined : no idle counter is built and timeout_o is tied to 0.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no owner; arbitrate round-robin starting at ptr+1
// LOCKED | owner gnt_id_o fixed until its 'last' byte (or a timeout)

module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                       clk_i,
  input  logic                       arst_ni,
  input  logic [NUM_REQ*8-1:0]       req_data_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ-1:0]         req_last_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic [7:0]                 tx_data_o,
  output logic                       tx_valid_o,
  input  logic                       tx_ready_i,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id_o,
  output logic                       gnt_valid_o,
  output logic                       timeout_o
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [7:0]      tx_data_q;
  logic            tx_valid_q;

  logic [7:0]      req_bytes [NUM_REQ];
  logic            owner_valid;
  logic            owner_last;
  logic            accept;
  logic            hs;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   cand;

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(IDLE_TIMEOUT - 1);
  logic [15:0]     idle_cnt_q, idle_cnt_d;
  logic            timeout_q, timeout_d;
`else
  logic            unused_timeout_cfg;
  assign unused_timeout_cfg = ^16'(IDLE_TIMEOUT);
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_bytes[i] = req_data_i[i*8 +: 8];
  end

  // The output register can take a byte when empty or draining this cycle.
  assign accept      = ~tx_valid_q | tx_ready_i;
  assign owner_valid = req_valid_i[gnt_q];
  assign owner_last  = req_last_i[gnt_q];
  assign hs          = (state_q == LOCKED) & owner_valid & accept;

  // Round-robin search upward from ptr+1 with wrap; the last owner is tried last.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IW'((int'(ptr_q) + off) % NUM_REQ);
      if (!pick_found && req_valid_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Only the owner sees ready, and only while locked.
  always_comb begin
    req_ready_o = '0;
    if (state_q == LOCKED) begin
      req_ready_o[gnt_q] = accept;
    end
  end

  // Next-state logic: grant in IDLE, release on the owner's last byte or on idle timeout.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
`ifdef UART_ARB_TIMEOUT_EN
    idle_cnt_d = idle_cnt_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef UART_ARB_TIMEOUT_EN
        idle_cnt_d = '0;
`endif
        if (pick_found) begin
          state_d = LOCKED;
          gnt_d   = pick_idx;
        end
      end
      LOCKED: begin
        if (hs) begin
`ifdef UART_ARB_TIMEOUT_EN
          idle_cnt_d = '0;
`endif
          if (owner_last) begin
            state_d = IDLE;
            ptr_d   = gnt_q;
          end
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (idle_cnt_q == TO_LIM) begin
          state_d    = IDLE;
          ptr_d      = gnt_q;
          timeout_d  = 1'b1;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 16'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, grant and fairness pointer registers; ptr resets so requester 0 wins first.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= IW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  // Idle counter and the one-cycle forced-release pulse.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  // Output byte register; drains on tx_ready_i independently of the FSM state.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else if (hs) begin
      tx_data_q  <= req_bytes[gnt_q];
      tx_valid_q <= 1'b1;
    end else if (tx_ready_i) begin
      tx_valid_q <= 1'b0;
    end
  end

  assign tx_data_o   = tx_data_q;
  assign tx_valid_o  = tx_valid_q;
  assign gnt_id_o    = gnt_q;
  assign gnt_valid_o = (state_q == LOCKED);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with two requesters.
// One table row per clock cycle: inputs are driven 1 ns after the rising
// edge and outputs are compared on the falling edge.

module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 2;
  localparam int IDLE_TIMEOUT = 8;

  logic        clk_i = 1'b0;
  logic        arst_ni = 1'b0;
  logic [15:0] req_data_i;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_last_i;
  logic [1:0]  req_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [0:0]  gnt_id_o;
  logic        gnt_valid_o;
  logic        timeout_o;

  int checks = 0;
  int errors = 0;
  int step   = 0;

  always #5 clk_i = ~clk_i;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .IDLE_TIMEOUT (IDLE_TIMEOUT)
  ) dut (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .req_data_i  (req_data_i),
    .req_valid_i (req_valid_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .gnt_id_o    (gnt_id_o),
    .gnt_valid_o (gnt_valid_o),
    .timeout_o   (timeout_o)
  );

  typedef struct {
    logic       rst;
    logic [1:0] v;
    logic [1:0] l;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       rdy;
    logic [1:0] rr;
    logic       tv;
    logic [7:0] td;
    logic       gv;
    logic       gid;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [1:0] v, input logic [1:0] l,
                     input logic [7:0] d0, input logic [7:0] d1, input logic rdy,
                     input logic [1:0] rr, input logic tv, input logic [7:0] td,
                     input logic gv, input logic gid);
    vec_t e;
    e.rst = rst; e.v = v; e.l = l; e.d0 = d0; e.d1 = d1; e.rdy = rdy;
    e.rr = rr; e.tv = tv; e.td = td; e.gv = gv; e.gid = gid;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask

  task automatic set_in(input logic rst, input logic [1:0] v, input logic [1:0] l,
                        input logic [7:0] d0, input logic [7:0] d1, input logic rdy);
    arst_ni     = rst;
    req_valid_i = v;
    req_last_i  = l;
    req_data_i  = {d1, d0};
    tx_ready_i  = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    set_in(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    step = -1;
    chk("rst_tx_valid",  32'(tx_valid_o),  32'd0);
    chk("rst_tx_data",   32'(tx_data_o),   32'd0);
    chk("rst_req_ready", 32'(req_ready_o), 32'd0);
    chk("rst_gnt_valid", 32'(gnt_valid_o), 32'd0);
    chk("rst_gnt_id",    32'(gnt_id_o),    32'd0);
    chk("rst_timeout",   32'(timeout_o),   32'd0);
    next_cycle();

    //  rst  v      l      d0     d1     rdy | rr     tv  td     gv  gid
    // req0 sends 41 42 43
    add(1, 2'b01, 2'b00, 8'h41, 8'h00, 1,   2'b00, 0,  8'h00, 0,  0);
    add(1, 2'b01, 2'b00, 8'h41, 8'h00, 1,   2'b01, 0,  8'h00, 1,  0);
    add(1, 2'b01, 2'b00, 8'h42, 8'h00, 1,   2'b01, 1,  8'h41, 1,  0);
    add(1, 2'b01, 2'b01, 8'h43, 8'h00, 1,   2'b01, 1,  8'h42, 1,  0);
    add(1, 2'b00, 2'b00, 8'h00, 8'h00, 1,   2'b00, 1,  8'h43, 0,  0);
    add(1, 2'b00, 2'b00, 8'h00, 8'h00, 1,   2'b00, 0,  8'h43, 0,  0);
    // reset, then both valid: 2-byte messages, then alternating rounds
    add(0, 2'b00, 2'b00, 8'h00, 8'h00, 1,   2'b00, 0,  8'h00, 0,  0);
    add(1, 2'b11, 2'b00, 8'hA0, 8'hB0, 1,   2'b00, 0,  8'h00, 0,  0);
    add(1, 2'b11, 2'b00, 8'hA0, 8'hB0, 1,   2'b01, 0,  8'h00, 1,  0);
    add(1, 2'b11, 2'b01, 8'hA1, 8'hB0, 1,   2'b01, 1,  8'hA0, 1,  0);
    add(1, 2'b11, 2'b00, 8'hA2, 8'hB0, 1,   2'b00, 1,  8'hA1, 0,  0);
    add(1, 2'b11, 2'b00, 8'hA2, 8'hB0, 1,   2'b10, 0,  8'hA1, 1,  1);
    add(1, 2'b11, 2'b10, 8'hA2, 8'hB1, 1,   2'b10, 1,  8'hB0, 1,  1);
    add(1, 2'b11, 2'b01, 8'hA2, 8'hB2, 1,   2'b00, 1,  8'hB1, 0,  1);
    add(1, 2'b11, 2'b01, 8'hA2, 8'hB2, 1,   2'b01, 0,  8'hB1, 1,  0);
    add(1, 2'b11, 2'b10, 8'hA3, 8'hB2, 1,   2'b00, 1,  8'hA2, 0,  0);
    add(1, 2'b11, 2'b10, 8'hA3, 8'hB2, 1,   2'b10, 0,  8'hA2, 1,  1);
    add(1, 2'b01, 2'b00, 8'hA3, 8'h00, 1,   2'b00, 1,  8'hB2, 0,  1);
    // tx_ready low for 5 cycles mid-message
    add(1, 2'b01, 2'b00, 8'hA3, 8'h00, 1,   2'b01, 0,  8'hB2, 1,  0);
    for (int k = 0; k < 5; k++)
      add(1, 2'b01, 2'b01, 8'hA4, 8'h00, 0, 2'b00, 1,  8'hA3, 1,  0);
    add(1, 2'b01, 2'b01, 8'hA4, 8'h00, 1,   2'b01, 1,  8'hA3, 1,  0);
    add(1, 2'b00, 2'b00, 8'h00, 8'h00, 1,   2'b00, 1,  8'hA4, 0,  0);
    add(1, 2'b00, 2'b00, 8'h00, 8'h00, 0,   2'b00, 0,  8'hA4, 0,  0);
    // reset while locked with a pending output byte
    add(1, 2'b10, 2'b00, 8'h00, 8'hC0, 0,   2'b00, 0,  8'hA4, 0,  0);
    add(1, 2'b10, 2'b00, 8'h00, 8'hC0, 0,   2'b10, 0,  8'hA4, 1,  1);
    add(1, 2'b10, 2'b00, 8'h00, 8'hC1, 0,   2'b00, 1,  8'hC0, 1,  1);
    add(0, 2'b10, 2'b00, 8'h00, 8'hC1, 0,   2'b00, 0,  8'h00, 0,  0);
    add(1, 2'b11, 2'b11, 8'hD0, 8'hC1, 1,   2'b00, 0,  8'h00, 0,  0);
    add(1, 2'b11, 2'b11, 8'hD0, 8'hC1, 1,   2'b01, 0,  8'h00, 1,  0);
    add(1, 2'b10, 2'b10, 8'h00, 8'hC1, 1,   2'b00, 1,  8'hD0, 0,  0);
    add(1, 2'b10, 2'b10, 8'h00, 8'hC1, 1,   2'b10, 0,  8'hD0, 1,  1);
    add(1, 2'b00, 2'b00, 8'h00, 8'h00, 1,   2'b00, 1,  8'hC1, 0,  1);
    add(1, 2'b00, 2'b00, 8'h00, 8'h00, 1,   2'b00, 0,  8'hC1, 0,  1);
    // owner drops valid while locked and keeps the lock
    add(1, 2'b01, 2'b00, 8'hE0, 8'h00, 1,   2'b00, 0,  8'hC1, 0,  1);
    add(1, 2'b10, 2'b00, 8'hE0, 8'hF0, 1,   2'b01, 0,  8'hC1, 1,  0);
    add(1, 2'b10, 2'b00, 8'hE0, 8'hF0, 1,   2'b01, 0,  8'hC1, 1,  0);
    add(1, 2'b01, 2'b01, 8'hE0, 8'hF0, 1,   2'b01, 0,  8'hC1, 1,  0);
    add(1, 2'b10, 2'b10, 8'h00, 8'hF0, 1,   2'b00, 1,  8'hE0, 0,  0);
    add(1, 2'b10, 2'b10, 8'h00, 8'hF0, 1,   2'b10, 0,  8'hE0, 1,  1);
    add(1, 2'b00, 2'b00, 8'h00, 8'h00, 1,   2'b00, 1,  8'hF0, 0,  1);

    foreach (tbl[i]) begin
      step = i;
      set_in(tbl[i].rst, tbl[i].v, tbl[i].l, tbl[i].d0, tbl[i].d1, tbl[i].rdy);
      @(negedge clk_i);
      chk("req_ready", 32'(req_ready_o), 32'(tbl[i].rr));
      chk("tx_valid",  32'(tx_valid_o),  32'(tbl[i].tv));
      chk("tx_data",   32'(tx_data_o),   32'(tbl[i].td));
      chk("gnt_valid", 32'(gnt_valid_o), 32'(tbl[i].gv));
      chk("gnt_id",    32'(gnt_id_o),    32'(tbl[i].gid));
      chk("timeout",   32'(timeout_o),   32'd0);
      next_cycle();
    end

    // Idle lock: req1 sends one byte without last, req0 then waits.
    step = 100;
    set_in(1'b1, 2'b10, 2'b00, 8'h00, 8'h55, 1'b1);
    @(negedge clk_i);
    chk("to_idle_gv", 32'(gnt_valid_o), 32'd0);
    next_cycle();
    step = 101;
    @(negedge clk_i);
    chk("to_grant_gid", 32'(gnt_id_o),    32'd1);
    chk("to_grant_rr",  32'(req_ready_o), 32'b10);
    next_cycle();
    set_in(1'b1, 2'b01, 2'b01, 8'h66, 8'h00, 1'b1);
    for (int t = 2; t <= 9; t++) begin
      step = 100 + t;
      @(negedge clk_i);
      chk("to_hold_gv",  32'(gnt_valid_o), 32'd1);
      chk("to_hold_gid", 32'(gnt_id_o),    32'd1);
      chk("to_hold_to",  32'(timeout_o),   32'd0);
      next_cycle();
    end
    step = 110;
    @(negedge clk_i);
    chk("to_tx_data",  32'(tx_data_o),  32'h55);
    chk("to_tx_valid", 32'(tx_valid_o), 32'd0);
`ifdef UART_ARB_TIMEOUT_EN
    chk("to_pulse",    32'(timeout_o),   32'd1);
    chk("to_release",  32'(gnt_valid_o), 32'd0);
`else
    chk("to_pulse",    32'(timeout_o),   32'd0);
    chk("to_kept",     32'(gnt_valid_o), 32'd1);
`endif
    next_cycle();
    step = 111;
    @(negedge clk_i);
    chk("to_after_to",  32'(timeout_o),   32'd0);
    chk("to_after_gv",  32'(gnt_valid_o), 32'd1);
`ifdef UART_ARB_TIMEOUT_EN
    chk("to_after_gid", 32'(gnt_id_o),    32'd0);
    chk("to_after_rr",  32'(req_ready_o), 32'b01);
`else
    chk("to_after_gid", 32'(gnt_id_o),    32'd1);
    chk("to_after_rr",  32'(req_ready_o), 32'b10);
`endif
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
